// File: rtl/dram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : dram_pkg                                                   |
// | Purpose : Default widths and FSM state encoding shared by the        |
// |           dram_burst_reader block and its FIFO.                      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dram_pkg;

  localparam int DRAM_ADDR_W     = 20;
  localparam int DRAM_DATA_W     = 8;
  localparam int DRAM_LEN_W      = 12;
  localparam int DRAM_FIFO_DEPTH = 8;
  localparam int DRAM_RD_LAT     = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/burst_rd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : burst_rd_fifo                                              |
// | Purpose : Synchronous FIFO holding {last, data} entries for the      |
// |           burst reader. Head entry is visible combinationally and    |
// |           reads as zero while empty.                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module burst_rd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset needed since empty masks the head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit logic guarantees a free slot for every write.
  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule
`default_nettype wire

// File: rtl/dram_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dram_burst_reader                                          |
// | Purpose : Accepts {addr, len} burst commands, issues one DRAM read   |
// |           per cycle (credit limited by FIFO space), captures rdata   |
// |           after RD_LAT and streams bytes out on valid/ready with a   |
// |           last marker and a done pulse per burst.                    |
// | Options : DRAM_BURST_READER_STATS_EN adds stall_cycles/burst_count.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dram_burst_reader
  import dram_pkg::*;
#(
  parameter int ADDR_W     = DRAM_ADDR_W,
  parameter int DATA_W     = DRAM_DATA_W,
  parameter int LEN_W      = DRAM_LEN_W,
  parameter int FIFO_DEPTH = DRAM_FIFO_DEPTH,
  parameter int RD_LAT     = DRAM_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              dram_ren,
  output logic [ADDR_W-1:0] dram_raddr,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef DRAM_BURST_READER_STATS_EN
  ,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       burst_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t             state;
  logic [ADDR_W-1:0]  base_addr;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   delivered;
  logic               dram_last;
  logic [RD_LAT-1:0]  vld_sr;
  logic [RD_LAT-1:0]  last_sr;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W:0]    fifo_rd_data;
  logic               pop;
  logic               credit_ok;
  int                 outstanding;

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rd_data[DATA_W-1:0];
  assign out_last  = fifo_rd_data[DATA_W];
  assign pop       = out_valid && out_ready;

  // Every read already on the wire or in the latency pipe owns a FIFO slot.
  always_comb begin
    outstanding = int'(fifo_count) + int'(dram_ren);
    for (int i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + int'(vld_sr[i]);
    end
    credit_ok = !fifo_full && (outstanding < FIFO_DEPTH);
  end

  // Burst FSM with registered command, DRAM and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      dram_ren   <= 1'b0;
      dram_raddr <= '0;
      dram_last  <= 1'b0;
      base_addr  <= '0;
      len        <= '0;
      issued     <= '0;
      delivered  <= '0;
    end else begin
      done      <= 1'b0;
      dram_ren  <= 1'b0;
      dram_last <= 1'b0;
      if (state != IDLE && pop) delivered <= delivered + LEN_ONE;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            base_addr <= cmd_addr;
            len       <= cmd_len;
            delivered <= '0;
            if (cmd_len == '0) begin
              // Empty burst completes without touching the DRAM.
              issued <= '0;
              done   <= 1'b1;
            end else begin
              // First read goes out straight from the accept edge.
              dram_ren   <= 1'b1;
              dram_raddr <= cmd_addr;
              dram_last  <= (cmd_len == LEN_ONE);
              issued     <= LEN_ONE;
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              state      <= (cmd_len == LEN_ONE) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            dram_ren   <= 1'b1;
            dram_raddr <= base_addr + ADDR_W'(issued);
            dram_last  <= (issued == len - LEN_ONE);
            issued     <= issued + LEN_ONE;
            if (issued == len - LEN_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (delivered == len - LEN_ONE)) begin
            state     <= IDLE;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency pipe: tracks which returning rdata cycles carry our bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= dram_ren;
      last_sr[0] <= dram_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  burst_rd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (vld_sr[RD_LAT-1]),
    .wr_data ({last_sr[RD_LAT-1], dram_rdata}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef DRAM_BURST_READER_STATS_EN
  // Saturating statistics, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      burst_count  <= '0;
    end else begin
      if (state == ISSUE && !dram_ren && stall_cycles != 16'hFFFF)
        stall_cycles <= stall_cycles + 16'd1;
      if (done && burst_count != 16'hFFFF)
        burst_count <= burst_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_dram_burst_reader                                       |
// | Purpose : Directed self-checking bench for dram_burst_reader with a  |
// |           one-cycle registered DRAM read model.                      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_dram_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [19:0] cmd_addr;
  logic [11:0] cmd_len;
  logic        dram_ren;
  logic [19:0] dram_raddr;
  logic [7:0]  dram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef DRAM_BURST_READER_STATS_EN
  logic [15:0] stall_cycles;
  logic [15:0] burst_count;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [19:0] addr_q[$];
  int          ren_cyc_q[$];
  logic [8:0]  out_q[$];
  int          out_cyc_q[$];
  int          done_q[$];
  int          hs_q[$];

  dram_burst_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .dram_ren   (dram_ren),
    .dram_raddr (dram_raddr),
    .dram_rdata (dram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef DRAM_BURST_READER_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .burst_count  (burst_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dram_f(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h5A;
  endfunction

  // DRAM model: registered read, data valid one edge after sampling ren.
  always @(posedge clk) begin
    if (dram_ren) dram_rdata <= dram_f(dram_raddr);
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dram_ren) begin
        addr_q.push_back(dram_raddr);
        ren_cyc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        out_q.push_back({out_last, out_data});
        out_cyc_q.push_back(cyc);
      end
      if (done) done_q.push_back(cyc);
      if (cmd_valid && cmd_ready) hs_q.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_q();
    addr_q.delete(); ren_cyc_q.delete(); out_q.delete();
    out_cyc_q.delete(); done_q.delete(); hs_q.delete();
  endtask

  task automatic send(input logic [19:0] a, input logic [11:0] l, output int k);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int i;
    i = 0;
    while (done_q.size() < n && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, 32'(done_q.size()), 32'(n));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_dram_ren"},  32'(dram_ren),  32'd0);
    check({tag, "_raddr"},     32'(dram_raddr), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_out_last"},  32'(out_last),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
  endtask

  // Addresses base+i (mod 2^20) and bytes dram_f(addr), last on the final one.
  task automatic check_stream(input string tag, input logic [19:0] base, input int len, input int off);
    logic [19:0] ea;
    logic [8:0]  eo;
    for (int i = 0; i < len; i++) begin
      ea = base + 20'(i);
      eo = {(i == len - 1), dram_f(ea)};
      check($sformatf("%s_addr%0d", tag, i),
            (off + i < addr_q.size()) ? 32'(addr_q[off+i]) : 32'hDEAD_BEEF, 32'(ea));
      check($sformatf("%s_byte%0d", tag, i),
            (off + i < out_q.size()) ? 32'(out_q[off+i]) : 32'hDEAD_BEEF, 32'(eo));
    end
  endtask

  initial begin
    int k;
    int i;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b1;
    dram_rdata = 8'h00;
    tick(3);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick(2);

    // Single burst: addr 0, len 3
    clear_q();
    send(20'h00000, 12'd3, k);
    check("single_ren_after_accept", 32'(dram_ren), 32'd1);
    check("single_raddr0", 32'(dram_raddr), 32'd0);
    check("single_cmd_ready_low", 32'(cmd_ready), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    wait_done("single_done_seen", 1, 50);
    tick(3);
    check("single_done_count", 32'(done_q.size()), 32'd1);
    check("single_nreads", 32'(addr_q.size()), 32'd3);
    check("single_nbytes", 32'(out_q.size()), 32'd3);
    check_stream("single", 20'h00000, 3, 0);
    check("single_ren_cyc0", (ren_cyc_q.size() > 2) ? 32'(ren_cyc_q[0]) : 32'hFFFF_FFFF, 32'(k));
    check("single_ren_cyc2", (ren_cyc_q.size() > 2) ? 32'(ren_cyc_q[2]) : 32'hFFFF_FFFF, 32'(k + 2));
    check("single_first_out_cyc", (out_cyc_q.size() > 0) ? 32'(out_cyc_q[0]) : 32'hFFFF_FFFF, 32'(k + 2));
    check("single_done_cyc", (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFF_FFFF, 32'(k + 5));
    check("single_busy_low", 32'(busy), 32'd0);
    check("single_cmd_ready_back", 32'(cmd_ready), 32'd1);

    // Wrap-around: addr 0xFFFFE, len 4
    clear_q();
    send(20'hFFFFE, 12'd4, k);
    wait_done("wrap_done_seen", 1, 50);
    tick(2);
    check("wrap_nreads", 32'(addr_q.size()), 32'd4);
    check_stream("wrap", 20'hFFFFE, 4, 0);

    // Backpressure: addr 0x0D7E1, len 20, consumer stalled
    clear_q();
    out_ready = 1'b0;
    send(20'h0D7E1, 12'd20, k);
    tick(30);
    check("bp_reads_before_stall", 32'(addr_q.size()), 32'd8);
    check("bp_ren_low", 32'(dram_ren), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head_byte", 32'(out_data), 32'(dram_f(20'h0D7E1)));
    check("bp_head_last", 32'(out_last), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    wait_done("bp_done_seen", 1, 200);
    tick(3);
    check("bp_nreads", 32'(addr_q.size()), 32'd20);
    check("bp_nbytes", 32'(out_q.size()), 32'd20);
    check("bp_done_count", 32'(done_q.size()), 32'd1);
    check_stream("bp", 20'h0D7E1, 20, 0);

    // Zero length
    clear_q();
    send(20'h12345, 12'd0, k);
    check("zero_done_pulse", 32'(done), 32'd1);
    check("zero_no_ren", 32'(dram_ren), 32'd0);
    check("zero_cmd_ready", 32'(cmd_ready), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    tick(1);
    check("zero_done_falls", 32'(done), 32'd0);
    tick(3);
    check("zero_nreads", 32'(addr_q.size()), 32'd0);
    check("zero_nbytes", 32'(out_q.size()), 32'd0);
    check("zero_done_count", 32'(done_q.size()), 32'd1);
    check("zero_out_valid", 32'(out_valid), 32'd0);

    // Reset mid-burst after 5 of 16 reads issued
    clear_q();
    send(20'h00100, 12'd16, k);
    i = 0;
    while (addr_q.size() < 5 && i < 50) begin
      tick(1);
      i++;
    end
    check("rst_reads_before_reset", 32'(addr_q.size()), 32'd5);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_q();
    send(20'h00010, 12'd2, k);
    wait_done("postrst_done_seen", 1, 50);
    tick(4);
    check("postrst_nreads", 32'(addr_q.size()), 32'd2);
    check("postrst_nbytes", 32'(out_q.size()), 32'd2);
    check_stream("postrst", 20'h00010, 2, 0);

    // Back-to-back: second command held valid during first burst
    clear_q();
    cmd_addr  = 20'h00200;
    cmd_len   = 12'd5;
    cmd_valid = 1'b1;
    tick(1);
    cmd_addr  = 20'h00300;
    cmd_len   = 12'd3;
    i = 0;
    while (hs_q.size() < 2 && i < 100) begin
      tick(1);
      i++;
    end
    cmd_valid = 1'b0;
    wait_done("b2b_done_seen", 2, 100);
    tick(3);
    check("b2b_handshakes", 32'(hs_q.size()), 32'd2);
    check("b2b_accept_in_done_cycle",
          (hs_q.size() > 1 && done_q.size() > 0) ? 32'(hs_q[1]) : 32'hFFFF_FFFF,
          (done_q.size() > 0) ? 32'(done_q[0]) : 32'hFFFF_FFFE);
    check("b2b_nbytes", 32'(out_q.size()), 32'd8);
    check_stream("b2b_first", 20'h00200, 5, 0);
    check_stream("b2b_second", 20'h00300, 3, 5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
